// File: rtl/hazard_stall_unit.sv
// Decode-stage hazard detector and mult/div occupancy tracker for the 5-stage pipeline.
// Optional stall-cycle performance counter is built when HAZ_PERF_CNT_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned MD_LAT = 32,
    parameter logic [2:0]  WS_MEM = 3'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RA1_D,
    input  logic [4:0] RA2_D,
    input  logic       use_rs_D,
    input  logic       use_rt_D,
    input  logic       branch_D,
    input  logic       hilo_rd_D,
    input  logic       md_start_D,
    input  logic [4:0] WA_E,
    input  logic       WE_E,
    input  logic [2:0] WS_E,
    input  logic       md_start_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_E,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    // state   | meaning
    // MD_IDLE | no multiply/divide in flight, HI/LO valid
    // MD_BUSY | multiply/divide running, r_md_cnt cycles remain before write-back
    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [7:0] MD_CNT_LOAD = 8'(MD_LAT - 1);

    md_state_t  r_md_state;
    md_state_t  w_md_state_nx;
    logic [7:0] r_md_cnt;
    logic [7:0] w_md_cnt_nx;

    logic w_dep_E;
    logic w_load_use;
    logic w_branch_haz;
    logic w_md_haz;
    logic w_stall;

    // Branches compare in ID, so any in-flight producer in E blocks them, not just loads.
    assign w_dep_E      = WE_E && (WA_E != 5'd0) &&
                          ((use_rs_D && (WA_E == RA1_D)) || (use_rt_D && (WA_E == RA2_D)));
    assign w_load_use   = w_dep_E && (WS_E == WS_MEM);
    assign w_branch_haz = w_dep_E && branch_D;
    assign w_md_haz     = (hilo_rd_D || md_start_D) && (md_busy || md_start_E);
    assign w_stall      = w_load_use || w_branch_haz || w_md_haz;

    assign stall_F = w_stall;
    assign stall_D = w_stall;
    assign flush_E = w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_state <= MD_IDLE;
            r_md_cnt   <= 8'd0;
        end else begin
            r_md_state <= w_md_state_nx;
            r_md_cnt   <= w_md_cnt_nx;
        end
    end

    always_comb begin
        w_md_state_nx = r_md_state;
        w_md_cnt_nx   = r_md_cnt;
        md_busy       = 1'b0;
        md_done       = 1'b0;
        case (r_md_state)
            MD_IDLE: begin
                if (md_start_E) begin
                    w_md_state_nx = MD_BUSY;
                    w_md_cnt_nx   = MD_CNT_LOAD;
                end
            end
            MD_BUSY: begin
                md_busy = 1'b1;
                md_done = (r_md_cnt == 8'd0);
                // A second launch while busy restarts the count rather than queuing.
                if (md_start_E) begin
                    w_md_cnt_nx = MD_CNT_LOAD;
                end else if (r_md_cnt == 8'd0) begin
                    w_md_state_nx = MD_IDLE;
                end else begin
                    w_md_cnt_nx = r_md_cnt - 8'd1;
                end
            end
            default: begin
                w_md_state_nx = MD_IDLE;
                w_md_cnt_nx   = 8'd0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-stage hazard and stall controller for the 5-stage MIPS pipeline. It sits beside the ID forwarding unit. It detects the dependencies that EX/MEM-to-ID forwarding cannot resolve:
- load-use hazards
- branch-compare operands still in EX
- HI/LO reads while the multi-cycle multiply/divide unit is busy

It drives the F/D stall enables and the D->E bubble flush, and tracks multiply/divide occupancy with an internal counter FSM.

## Interface
- MD_LAT, 32, multiply/divide latency in cycles; legal range 2..255
- WS_MEM, 3'd1, write-source code meaning "load data from memory"
- clk  input  1  pipeline clock, rising edge
- rst  input  1  synchronous, active-high reset
- RA1_D  input  5  rs address of the instruction in D
- RA2_D  input  5  rt address of the instruction in D
- use_rs_D  input  1  instruction in D reads rs
- use_rt_D  input  1  instruction in D reads rt
- branch_D  input  1  instruction in D is a branch that compares operands in ID
- hilo_rd_D  input  1  instruction in D is MFHI/MFLO
- md_start_D  input  1  instruction in D is MULT/MULTU/DIV/DIVU
- WA_E  input  5  destination register of the instruction in E
- WE_E  input  1  the instruction in E writes the register file
- WS_E  input  3  write-source select of the instruction in E
- md_start_E  input  1  a mult/div is in E this cycle; the unit launches on this edge
- stall_F  output  1  hold the PC
- stall_D  output  1  hold the F/D register
- flush_E  output  1  load a bubble into the D/E register
- md_busy  output  1  mult/div in progress (registered)
- md_done  output  1  one-cycle pulse: the HI/LO write-back edge
- stall_cnt  output  32  total stall cycles; present only with HAZ_PERF_CNT_EN

## Operation
- Define dep_E = WE_E && WA_E != 0 && ((use_rs_D && WA_E == RA1_D) || (use_rt_D && WA_E == RA2_D)).
- load_use = dep_E && WS_E == WS_MEM.
- branch_haz = dep_E && branch_D. This applies for any WS_E, because branch operands must be valid in D.
- md_haz = (hilo_rd_D || md_start_D) && (md_busy || md_start_E).
- stall = load_use || branch_haz || md_haz.
- stall_F = stall_D = flush_E = stall. All three are combinational.
- The mult/div FSM has two states:
  - IDLE: md_busy=0. On md_start_E, go to BUSY with cnt = MD_LAT-1.
  - BUSY: md_busy=1, cnt decrements each edge. When cnt == 0, the next edge goes to IDLE and md_done=1 for that cycle. md_done is combinational: BUSY && cnt==0.
  - md_start_E while in BUSY is a protocol violation. It restarts the count: cnt = MD_LAT-1, state stays BUSY.
- The 8-bit counter never wraps. It only loads or decrements down to 0.
- A hazard in D holds until it clears. Multiple simultaneous causes produce a single stall, not additive stalls.
- Reset mid-operation aborts the mult/div: state IDLE, cnt 0. No md_done is generated.

## Timing
- Reset values: state IDLE, cnt 0, md_busy 0, md_done 0, stall_cnt 0.
- Stall outputs settle from current-cycle inputs, with zero latency.
- Load-use and branch hazards each produce exactly 1 stall cycle. The producer then advances to M, where ID forwarding covers it.
- md_start_E at edge t: md_busy is high for cycles t+1..t+MD_LAT. md_done is high in cycle t+MD_LAT. md_busy falls at edge t+MD_LAT+1.
- A dependent MFHI in D stalls through the md_done cycle and issues the following cycle.
- A register-0 destination never causes a stall.

## Configuration
- HAZ_PERF_CNT_EN defined:
  - stall_cnt increments by 1 on every edge where stall=1.
  - It saturates at 32'hFFFF_FFFF.
  - rst clears it.
- HAZ_PERF_CNT_EN undefined: the stall_cnt port and the counter logic are absent. All other behaviour is identical.

## Test plan
- LW r5 in E (WE_E=1, WA_E=5, WS_E=WS_MEM); ADD reading r5 via rs in D -> stall_F=stall_D=flush_E=1 for 1 cycle; the next cycle all are 0.
- ADD r3 in E (WS_E=0); BEQ in D reading r3 -> 1-cycle stall. The same ADD with a non-branch consumer -> no stall.
- WA_E=0 with WE_E=1 and RA1_D=0, use_rs_D=1 -> no stall.
- md_start_E pulse at cycle 10, MD_LAT=32 -> md_busy high cycles 11..42, md_done high at 42. An MFLO held in D from cycle 11 stalls through 42 and issues in 43.
- rst asserted at cycle 20 of a busy mult/div -> md_busy=0 next cycle, no md_done, stall released.
- With HAZ_PERF_CNT_EN: run the load-use, branch, and MD sequences above -> stall_cnt = 1 + 1 + 32. Reset -> 0.
